// File: rtl/tdo_shift_if.sv
// Request/transmitter bundle shared between the TDO arbiter and its neighbours.
// slave = arbiter side, master = requesters, TAP and transmitter side.
interface tdo_shift_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic                     shift_en;
   logic                     abort;
   logic [NUM_REQ-1:0]       grant;
   logic [NUM_REQ-1:0]       ack;
   logic                     xfer_abort;
   logic                     timeout_err;
   logic                     busy;
   logic [WIDTH-1:0]         tx_data;
   logic                     tx_enable;
   logic                     tx_done;

   modport slave (
      input  req, req_data, shift_en, abort, tx_done,
      output grant, ack, xfer_abort, timeout_err, busy, tx_data, tx_enable
   );

   modport master (
      output req, req_data, shift_en, abort, tx_done,
      input  grant, ack, xfer_abort, timeout_err, busy, tx_data, tx_enable
   );
endinterface

// File: rtl/tdo_shift_arbiter.sv
// Round-robin arbiter sharing one serial TDO transmitter between NUM_REQ sources.
// Latches the winner's word, enables the shift, and acks or aborts the owner.
module tdo_shift_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 40
) (
   input logic        clk,
   input logic        rst_n,
   tdo_shift_if.slave bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t             state_reg, state_next;
   logic [PTR_W-1:0]   rr_ptr_reg, owner_reg, winner;
   logic               win_valid;
   logic [WD_W-1:0]    wdog_reg;
   logic [NUM_REQ-1:0] grant_reg;
   logic [WIDTH-1:0]   tx_data_reg;
   logic               xfer_abort_reg, timeout_err_reg;
   logic               start, cancel, wd_fire;
   int                 idx;

   // Scan from furthest offset down so the nearest requester after rr_ptr wins.
   always_comb begin
      winner    = '0;
      win_valid = 1'b0;
      idx       = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
         if (bus.req[idx]) begin
            winner    = PTR_W'(idx);
            win_valid = 1'b1;
         end
      end
   end

   assign start   = bus.shift_en & win_valid & ~bus.abort;
   assign cancel  = ~bus.shift_en | bus.abort;
   assign wd_fire = (wdog_reg == WD_W'(TIMEOUT - 1)) & ~bus.tx_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = LOAD;
         LOAD:    state_next = SHIFT;
         SHIFT: begin
            if (cancel || wd_fire) begin
               state_next = IDLE;
            end else if (bus.tx_done) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.tx_enable = (state_reg == SHIFT);
      bus.busy      = (state_reg != IDLE);
      bus.ack       = (state_reg == DONE) ? grant_reg : '0;
   end

   // Cancellation leaves rr_ptr alone so the interrupted requester is retried first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_reg      <= PTR_W'(NUM_REQ - 1);
         owner_reg       <= '0;
         wdog_reg        <= '0;
         grant_reg       <= '0;
         tx_data_reg     <= '0;
         xfer_abort_reg  <= 1'b0;
         timeout_err_reg <= 1'b0;
      end else begin
         xfer_abort_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  grant_reg   <= NUM_REQ'(1) << winner;
                  owner_reg   <= winner;
                  tx_data_reg <= bus.req_data[winner*WIDTH +: WIDTH];
               end
            end
            LOAD: begin
               wdog_reg <= '0;
            end
            SHIFT: begin
               wdog_reg <= wdog_reg + 1'b1;
               if (cancel || wd_fire) begin
                  grant_reg      <= '0;
                  xfer_abort_reg <= 1'b1;
                  if (!cancel) timeout_err_reg <= 1'b1;
               end
            end
            DONE: begin
               grant_reg  <= '0;
               rr_ptr_reg <= owner_reg;
            end
            default: ;
         endcase
      end
   end

   assign bus.grant       = grant_reg;
   assign bus.tx_data     = tx_data_reg;
   assign bus.xfer_abort  = xfer_abort_reg;
   assign bus.timeout_err = timeout_err_reg;
endmodule

// File: tb/tb_tdo_shift_arbiter.sv
// Directed bench for tdo_shift_arbiter: arbitration order, abort paths, watchdog, async reset.
module tb_tdo_shift_arbiter;
   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 40;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [NUM_REQ*WIDTH-1:0] words;

   tdo_shift_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

   tdo_shift_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("check %-14s observed %0h expected %0h", tag, obs, exp);
   endtask

   // One complete transfer starting from IDLE with the winner's req already set.
   task automatic run_xfer(input int who, input int cycles);
      logic [NUM_REQ-1:0] oh;
      logic [WIDTH-1:0]   w;
      oh = NUM_REQ'(1) << who;
      w  = words[who*WIDTH +: WIDTH];
      tick();
      chk("xf_grant", 64'(bus.grant), 64'(oh));
      chk("xf_txdata", 64'(bus.tx_data), 64'(w));
      chk("xf_load_en", 64'(bus.tx_enable), 64'd0);
      tick();
      chk("xf_shift_en", 64'(bus.tx_enable), 64'd1);
      repeat (cycles - 1) tick();
      chk("xf_no_ack", 64'(bus.ack), 64'd0);
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      chk("xf_ack", 64'(bus.ack), 64'(oh));
      chk("xf_done_en", 64'(bus.tx_enable), 64'd0);
      chk("xf_no_abort", 64'(bus.xfer_abort), 64'd0);
      tick();
      chk("xf_ack_clr", 64'(bus.ack), 64'd0);
      chk("xf_grant_clr", 64'(bus.grant), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "time limit");
   end

   initial begin
      words        = {32'h3333_DDDD, 32'h2222_CCCC, 32'h1111_BBBB, 32'h0000_AAAA};
      rst_n        = 1'b0;
      bus.req      = 4'b0001;
      bus.req_data = words;
      bus.shift_en = 1'b1;
      bus.abort    = 1'b0;
      bus.tx_done  = 1'b0;

      // 1: reset values, then first transfer to requester 0
      repeat (2) tick();
      chk("rst_grant", 64'(bus.grant), 64'd0);
      chk("rst_ack", 64'(bus.ack), 64'd0);
      chk("rst_xabort", 64'(bus.xfer_abort), 64'd0);
      chk("rst_txen", 64'(bus.tx_enable), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_tmo", 64'(bus.timeout_err), 64'd0);
      chk("rst_txdata", 64'(bus.tx_data), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("t1_grant", 64'(bus.grant), 64'h1);
      chk("t1_txdata", 64'(bus.tx_data), 64'h0000_AAAA);
      chk("t1_busy", 64'(bus.busy), 64'd1);
      bus.req_data[31:0] = 32'hDEAD_BEEF;
      bus.req = 4'b0000;
      tick();
      chk("t1_txen", 64'(bus.tx_enable), 64'd1);
      repeat (5) tick();
      chk("t1_txen_hold", 64'(bus.tx_enable), 64'd1);
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      chk("t1_ack", 64'(bus.ack), 64'h1);
      chk("t1_data_hold", 64'(bus.tx_data), 64'h0000_AAAA);
      tick();
      chk("t1_ack_clr", 64'(bus.ack), 64'd0);
      chk("t1_idle", 64'(bus.busy), 64'd0);
      bus.req_data = words;

      // 2: all requesting, fresh reset -> 0,1,2,3,0,1,2,3
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.req = 4'b1111;
      for (int i = 0; i < 8; i++) run_xfer(i % 4, 3 + i);
      bus.req = 4'b0010;
      run_xfer(1, 4);
      bus.req = 4'b0000;

      // 3: shift_en drop mid-shift; requester 2 retried ahead of 1
      bus.req = 4'b0100;
      tick();
      chk("t3_grant", 64'(bus.grant), 64'h4);
      tick();
      repeat (9) tick();
      bus.shift_en = 1'b0;
      bus.req = 4'b0110;
      tick();
      chk("t3_xabort", 64'(bus.xfer_abort), 64'd1);
      chk("t3_no_ack", 64'(bus.ack), 64'd0);
      chk("t3_grant0", 64'(bus.grant), 64'd0);
      chk("t3_txen", 64'(bus.tx_enable), 64'd0);
      tick();
      chk("t3_pulse", 64'(bus.xfer_abort), 64'd0);
      chk("t3_hold", 64'(bus.grant), 64'd0);
      bus.shift_en = 1'b1;
      run_xfer(2, 6);
      bus.req = 4'b0000;

      // 4: tx_done and abort together -> abort wins
      bus.req = 4'b0001;
      tick();
      chk("t4_grant", 64'(bus.grant), 64'h1);
      tick();
      repeat (3) tick();
      bus.tx_done = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      bus.abort = 1'b0;
      bus.req = 4'b0000;
      chk("t4_xabort", 64'(bus.xfer_abort), 64'd1);
      chk("t4_no_ack", 64'(bus.ack), 64'd0);
      chk("t4_grant0", 64'(bus.grant), 64'd0);
      tick();
      chk("t4_pulse", 64'(bus.xfer_abort), 64'd0);
      chk("t4_no_ack2", 64'(bus.ack), 64'd0);
      bus.req = 4'b0001;
      bus.abort = 1'b1;
      tick();
      chk("t4_idle_blk", 64'(bus.grant), 64'd0);
      bus.abort = 1'b0;
      tick();
      chk("t4_regrant", 64'(bus.grant), 64'h1);
      tick();
      bus.tx_done = 1'b1;
      bus.req = 4'b0000;
      tick();
      bus.tx_done = 1'b0;
      chk("t4_ack", 64'(bus.ack), 64'h1);
      tick();

      // 5: watchdog after TIMEOUT cycles in SHIFT; sticky flag
      bus.req = 4'b1000;
      tick();
      chk("t5_grant", 64'(bus.grant), 64'h8);
      tick();
      repeat (TIMEOUT - 1) tick();
      chk("t5_still_en", 64'(bus.tx_enable), 64'd1);
      chk("t5_no_tmo", 64'(bus.timeout_err), 64'd0);
      tick();
      chk("t5_xabort", 64'(bus.xfer_abort), 64'd1);
      chk("t5_tmo", 64'(bus.timeout_err), 64'd1);
      chk("t5_txen", 64'(bus.tx_enable), 64'd0);
      chk("t5_grant0", 64'(bus.grant), 64'd0);
      bus.req = 4'b0000;
      tick();
      chk("t5_pulse", 64'(bus.xfer_abort), 64'd0);
      bus.req = 4'b0010;
      run_xfer(1, 5);
      bus.req = 4'b0000;
      chk("t5_sticky", 64'(bus.timeout_err), 64'd1);

      // 6: async reset mid-shift
      bus.req = 4'b0100;
      tick();
      chk("t6_grant", 64'(bus.grant), 64'h4);
      tick();
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_txen", 64'(bus.tx_enable), 64'd0);
      chk("t6_grant0", 64'(bus.grant), 64'd0);
      chk("t6_busy", 64'(bus.busy), 64'd0);
      chk("t6_tmo_clr", 64'(bus.timeout_err), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.req = 4'b1111;
      tick();
      chk("t6_restart", 64'(bus.grant), 64'h1);
      chk("t6_no_ack", 64'(bus.ack), 64'd0);
      bus.req = 4'b0000;
      tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      chk("t6_ack", 64'(bus.ack), 64'h1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
